// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the programmable Mealy sequence detector.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;
  // Widest pattern the mask helper can describe.
  localparam int MASK_W      = 64;

  // A length of zero or anything above max falls back to max.
  function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] max);
    logic [31:0] res;
    if ((len == 32'd0) || (len > max)) begin
      res = max;
    end else begin
      res = len;
    end
    return res;
  endfunction

  // Mask with the low len bits set; callers slice it down to their pattern width.
  function automatic logic [MASK_W-1:0] len_mask(input logic [31:0] len);
    logic [MASK_W-1:0] m;
    m = {MASK_W{1'b0}};
    for (int i = 0; i < MASK_W; i++) begin
      m[i] = (32'(i) < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter: clear has priority, increment stops at all-ones.
module seq_det_match_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_n;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_n = cnt_r;
    if (clr) begin
      cnt_n = {W{1'b0}};
    end else if (inc && (cnt_r != {W{1'b1}})) begin
      cnt_n = cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_n = cnt_r;
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {W{1'b0}};
    end else begin
      cnt_r <= cnt_n;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/seq_det_mealy_param.sv
// Runtime-programmable Mealy sequence detector. The pattern, its length and the
// overlap mode are latched on cfg_load; accepted bits shift into a history
// register and a match is flagged combinationally in the cycle of the last bit.
module seq_det_mealy_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               en,
  input  logic               in,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt
);

  // fill counts 0..MAX_LEN-1
  localparam int FILL_W = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN - 1);
  localparam logic [LEN_W-1:0]  LEN_RST  = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pat_r, pat_n;
  logic [LEN_W-1:0]   len_r, len_n;
  logic               ovl_r, ovl_n;
  logic [MAX_LEN-2:0] hist_r, hist_n;
  logic [FILL_W-1:0]  fill_r, fill_n;

  logic [MAX_LEN-1:0] cand_s;
  logic [MASK_W-1:0]  mask_full_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               fill_ok_s;
  logic               match_s;

  assign cand_s      = {hist_r, in};
  assign mask_full_s = len_mask(32'(len_r));
  assign mask_s      = mask_full_s[MAX_LEN-1:0];
  // Enough history for the completing bit to finish a len_r-bit word.
  assign fill_ok_s   = ((32'(fill_r) + 32'd1) >= 32'(len_r));

  // A match needs an accepted bit, enough history and equal low len_r bits;
  // held low while reset is asserted.
  assign match_s = rst && en && !cfg_load && fill_ok_s &&
                   ((cand_s & mask_s) == (pat_r & mask_s));
  assign out     = match_s;

  // Next-state: configuration load, bit acceptance or hold.
  always_comb begin
    pat_n  = pat_r;
    len_n  = len_r;
    ovl_n  = ovl_r;
    hist_n = hist_r;
    fill_n = fill_r;
    if (cfg_load) begin
      pat_n  = cfg_pattern;
      len_n  = LEN_W'(clamp_len(32'(cfg_len), 32'(MAX_LEN)));
      ovl_n  = cfg_overlap;
      hist_n = {(MAX_LEN-1){1'b0}};
      fill_n = {FILL_W{1'b0}};
    end else if (en) begin
      hist_n = cand_s[MAX_LEN-2:0];
      if (match_s && !ovl_r) begin
        // Non-overlap: a match restarts detection from an empty history.
        fill_n = {FILL_W{1'b0}};
      end else if (fill_r == FILL_MAX) begin
        fill_n = FILL_MAX;
      end else begin
        fill_n = fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
      end
    end else begin
      fill_n = fill_r;
    end
  end

  // State registers; reset restores the default configuration and empty history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_r  <= {MAX_LEN{1'b0}};
      len_r  <= LEN_RST;
      ovl_r  <= 1'b1;
      hist_r <= {(MAX_LEN-1){1'b0}};
      fill_r <= {FILL_W{1'b0}};
    end else begin
      pat_r  <= pat_n;
      len_r  <= len_n;
      ovl_r  <= ovl_n;
      hist_r <= hist_n;
      fill_r <= fill_n;
    end
  end

  seq_det_match_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cfg_load),
    .inc (match_s),
    .cnt (match_cnt)
  );

endmodule
